// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  fifo_sync_param
//  Parametrised single-clock FIFO with occupancy count, threshold flags,
//  sticky overflow/underflow and synchronous flush.
//  Revision: 1.0
// ============================================================================
module fifo_sync_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         datin,
    input  logic                     rd,
    output logic [WIDTH-1:0]         datout,
    output logic                     dato,
    output logic                     full,
    output logic                     empy,
    output logic                     afull,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LVL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LVL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wptr_q,   wptr_d;
    logic [AW-1:0]    rptr_q,   rptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] datout_q, datout_d;
    logic             dato_q,   dato_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;

    logic             w_full;
    logic             w_empy;
    logic             w_rd_ok;
    logic             w_wr_ok;

    // All status flags decode the registered count only, so they move on edges.
    assign w_full  = (count_q == C_DEPTH);
    assign w_empy  = (count_q == '0);
    assign w_rd_ok = rd & ~w_empy;
    assign w_wr_ok = wr & (~w_full | w_rd_ok);

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        datout_d = datout_q;
        dato_d   = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (w_wr_ok) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (w_rd_ok) begin
                rptr_d   = rptr_q + 1'b1;
                datout_d = mem[rptr_q];
                dato_d   = 1'b1;
            end
            if (w_wr_ok && !w_rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                count_d = count_q - 1'b1;
            end
            if (wr && !w_wr_ok) begin
                ovf_d = 1'b1;
            end
            if (rd && !w_rd_ok) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            datout_q <= '0;
            dato_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            datout_q <= datout_d;
            dato_q   <= dato_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; a write is suppressed while reset or flush wins.
    always_ff @(posedge clk) begin
        if (rst && !clr && w_wr_ok) begin
            mem[wptr_q] <= datin;
        end
    end

    assign datout = datout_q;
    assign dato   = dato_q;
    assign count  = count_q;
    assign full   = w_full;
    assign empy   = w_empy;
    assign afull  = (count_q >= C_AF);
    assign aempty = (count_q <= C_AE);
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  tb_fifo_sync_param
//  Scoreboard bench for fifo_sync_param (WIDTH=3, DEPTH=4, AF=3, AE=1).
//  Revision: 1.0
// ============================================================================
module tb_fifo_sync_param;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       wr;
    logic [2:0] datin;
    logic       rd;
    logic [2:0] datout;
    logic       dato;
    logic       full;
    logic       empy;
    logic       afull;
    logic       aempty;
    logic [2:0] count;
    logic       ovf;
    logic       udf;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q [$];

    fifo_sync_param #(
        .WIDTH (3),
        .DEPTH (4),
        .AF_LVL(3),
        .AE_LVL(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .wr    (wr),
        .datin (datin),
        .rd    (rd),
        .datout(datout),
        .dato  (dato),
        .full  (full),
        .empy  (empy),
        .afull (afull),
        .aempty(aempty),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, return at the following negedge.
    task automatic step(input logic w, input logic [2:0] d, input logic r);
        wr    = w;
        datin = d;
        rd    = r;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic read_exp(input logic [2:0] v);
        exp_q.push_back(v);
        step(1'b0, 3'd0, 1'b1);
    endtask

    task automatic rw_exp(input logic [2:0] d, input logic [2:0] v);
        exp_q.push_back(v);
        step(1'b1, d, 1'b1);
    endtask

    // Monitor: every dato strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (dato === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL dato_unexpected: got datout=%0d expected no strobe", datout);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (datout !== e) begin
                    errors++;
                    $display("FAIL read_data: got %0d expected %0d", datout, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b0;
        clr   = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        datin = 3'd0;
        @(negedge clk);
        step(1'b0, 3'd0, 1'b0);
        step(1'b0, 3'd0, 1'b0);
        chk("rst_count",  count,  0);
        chk("rst_empy",   empy,   1);
        chk("rst_full",   full,   0);
        chk("rst_afull",  afull,  0);
        chk("rst_aempty", aempty, 1);
        chk("rst_ovf",    ovf,    0);
        chk("rst_udf",    udf,    0);
        chk("rst_datout", datout, 0);
        chk("rst_dato",   dato,   0);
        rst = 1'b1;

        // Fill 2,6,4,1
        step(1'b1, 3'd2, 1'b0);
        chk("fill1_count", count, 1);
        chk("fill1_aempty", aempty, 1);
        step(1'b1, 3'd6, 1'b0);
        chk("fill2_count", count, 2);
        chk("fill2_aempty", aempty, 0);
        chk("fill2_afull", afull, 0);
        step(1'b1, 3'd4, 1'b0);
        chk("fill3_count", count, 3);
        chk("fill3_afull", afull, 1);
        chk("fill3_full", full, 0);
        step(1'b1, 3'd1, 1'b0);
        chk("fill4_count", count, 4);
        chk("fill4_full", full, 1);
        chk("fill4_ovf", ovf, 0);

        // Overflow
        step(1'b1, 3'd7, 1'b0);
        chk("ovf_count", count, 4);
        chk("ovf_set", ovf, 1);
        read_exp(3'd2);
        read_exp(3'd6);
        read_exp(3'd4);
        read_exp(3'd1);
        chk("drain_empy", empy, 1);
        chk("ovf_sticky", ovf, 1);

        // Simultaneous rd/wr on empty: write only, underflow flagged
        step(1'b1, 3'd5, 1'b1);
        chk("udf_set", udf, 1);
        chk("udf_dato", dato, 0);
        chk("udf_count", count, 1);
        read_exp(3'd5);
        chk("udf_drain_count", count, 0);

        clr = 1'b1;
        step(1'b0, 3'd0, 1'b0);
        clr = 1'b0;
        chk("clr1_ovf", ovf, 0);

        // Simultaneous rd/wr on full
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        rw_exp(3'd7, 3'd1);
        chk("rwfull_count", count, 4);
        chk("rwfull_ovf", ovf, 0);
        read_exp(3'd2);
        read_exp(3'd3);
        read_exp(3'd4);
        read_exp(3'd7);
        chk("rwfull_empy", empy, 1);

        // Wrap-around: interleaved single write then read
        for (int i = 0; i < 5; i++) begin
            logic [2:0] v;
            v = 3'((i * 3) % 8);
            step(1'b1, v, 1'b0);
            chk("wrap_count_w", count, 1);
            read_exp(v);
            chk("wrap_count_r", count, 0);
        end

        // Flush with content and sticky flags set
        step(1'b0, 3'd0, 1'b1);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        read_exp(3'd1);
        chk("preclr_ovf", ovf, 1);
        chk("preclr_udf", udf, 1);
        chk("preclr_count", count, 3);
        clr = 1'b1;
        step(1'b1, 3'd6, 1'b0);
        clr = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_empy", empy, 1);
        chk("clr_ovf", ovf, 0);
        chk("clr_udf", udf, 0);
        chk("clr_datout_hold", datout, 1);
        step(1'b0, 3'd0, 1'b1);
        chk("clr_wr_dropped", count, 0);
        chk("clr_post_udf", udf, 1);

        // Same scenario, reset instead of flush
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd4, 1'b0);
        step(1'b1, 3'd5, 1'b0);
        read_exp(3'd1);
        chk("prerst_ovf", ovf, 1);
        chk("prerst_datout", datout, 1);
        rst = 1'b0;
        step(1'b1, 3'd6, 1'b0);
        rst = 1'b1;
        chk("mrst_count", count, 0);
        chk("mrst_empy", empy, 1);
        chk("mrst_ovf", ovf, 0);
        chk("mrst_udf", udf, 0);
        chk("mrst_datout", datout, 0);
        step(1'b0, 3'd0, 1'b1);
        chk("mrst_wr_dropped", count, 0);

        step(1'b0, 3'd0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock FIFO; next generation of the team's 3-bit dual-clock FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, sticky overflow/underflow flags and a synchronous flush. Sits between a producer and consumer in the same clock domain, with the same `wr`/`rd`/`full`/`empy`/`dato` handshake as the existing FIFO.

## Interface
- `WIDTH`, 8: data width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_LVL`, DEPTH-2: `afull` asserts when count ≥ AF_LVL; 1..DEPTH.
- `AE_LVL`, 1: `aempty` asserts when count ≤ AE_LVL; 0..DEPTH-1.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `clr`  in  1  synchronous flush, active-high.
- `wr`  in  1  write request.
- `datin`  in  WIDTH  write data.
- `rd`  in  1  read request.
- `datout`  out  WIDTH  read data, registered.
- `dato`  out  1  one-cycle strobe: `datout` was loaded by the previous edge.
- `full`  out  1  count == DEPTH.
- `empy`  out  1  count == 0.
- `afull`  out  1  count ≥ AF_LVL.
- `aempty`  out  1  count ≤ AE_LVL.
- `count`  out  clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- `ovf`  out  1  sticky: a write was rejected.
- `udf`  out  1  sticky: a read was rejected.

## Operation
- Storage: DEPTH × WIDTH array; write pointer and read pointer are clog2(DEPTH) bits each.
  - Pointers wrap modulo DEPTH naturally.
  - `count` is a separate register; it is the only source of the status flags.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd & ~empy.
  - wr_ok = wr & (~full | rd_ok).
- Full with rd & wr: both are accepted; count stays DEPTH.
- Empty with rd & wr: the write is accepted, the read is rejected (no fall-through); count goes 0→1 and `udf` sets.
- Rejected write (wr & full & ~rd_ok):
  - data is dropped; pointers and count are unchanged;
  - `ovf` sets and holds until `rst` or `clr`.
- Rejected read (rd & empy):
  - `datout` holds its value; `dato` = 0;
  - `udf` sets and holds until `rst` or `clr`.
- Accepted read: `datout` ← mem[rptr]; rptr advances; `dato` = 1 for the following cycle.
- Accepted write: mem[wptr] ← `datin`; wptr advances.
- count update:
  - +1 when wr_ok & ~rd_ok;
  - −1 when rd_ok & ~wr_ok;
  - unchanged otherwise.
- `clr` (when `rst` = 1):
  - pointers, count, `ovf`, `udf` and `dato` go to 0;
  - `datout` holds its value; memory contents are don't-care;
  - wr and rd in the same cycle are ignored, and their flags are not set.
- Priority: `rst` low > `clr` > normal operation.

## Timing
- Reset (`rst` = 0 at an edge): after that edge, and for as long as `rst` is held low:
  - `datout` = 0, `dato` = 0, `count` = 0;
  - `empy` = 1, `full` = 0, `afull` = 0, `aempty` = 1;
  - `ovf` = 0, `udf` = 0.
- Reset mid-operation discards all contents; the first edge with `rst` = 1 behaves as normal operation from empty.
- Write latency: a write accepted at edge k makes `empy` = 0 and count +1 after edge k. A read may be issued in the next cycle and is accepted at edge k+1.
- Read latency: one cycle. For a read accepted at edge m, `datout` and `dato` are valid after edge m.
- Back-to-back reads give a new word every cycle, with `dato` held high.
- Flags are combinational decodes of registered `count`, so they change only on clock edges and update on the same edge as `count`. No flag glitches between edges.
- Sustained throughput is one write and one read per cycle.

## Test plan
Parameters: WIDTH=3, DEPTH=4, AF_LVL=3, AE_LVL=1.
- Reset and fill:
  - Stimulus: `rst` low for 2 cycles, release, then write 2, 6, 4, 1 on consecutive cycles.
  - Required: count goes 1, 2, 3, 4; `aempty` drops after the 2nd write; `afull` rises after the 3rd; `full` rises after the 4th; `ovf` = 0.
- Overflow:
  - Stimulus: with the FIFO full, write 7 with rd = 0.
  - Required: count stays 4; `ovf` = 1 and stays set.
  - Then read 4 times: `datout` = 2, 6, 4, 1 with `dato` high, `empy` = 1 after the last read, and 7 never appears.
- Underflow and simultaneous access on empty:
  - Stimulus: from empty, rd = 1 and wr = 1 with `datin` = 5.
  - Required: `udf` = 1, `dato` = 0, count = 1.
  - Next cycle rd = 1: `datout` = 5.
- Simultaneous access on full:
  - Stimulus: fill with 1, 2, 3, 4, then rd = wr = 1 with `datin` = 7.
  - Required: count stays 4, `ovf` = 0, `datout` = 1.
  - Drain: 2, 3, 4, 7.
- Wrap-around:
  - Stimulus: 10 cycles of interleaved single writes and reads of values 0..7.
  - Required: `datout` sequence matches the write sequence exactly, and count stays within 0..1.
- Flush and reset mid-operation:
  - Stimulus: write 3 words with `ovf`/`udf` set, then pulse `clr` with wr = 1.
  - Required: after the pulse count = 0, `empy` = 1, `ovf` = `udf` = 0, and the write is dropped.
  - Repeat with `rst` low instead: additionally `datout` = 0.
